// File: rtl/div_const_pkg.sv
// Shared constants and types for the constant divide-by-5 family, so the divider
// and the reconstructor agree on quotient, remainder and dividend widths.
package div_const_pkg;

   localparam int DIVISOR = 5;
   localparam int Q_W     = 30;
   localparam int R_W     = 3;
   localparam int X_W     = 32;
   localparam int S_W     = X_W + 1;

   localparam logic [R_W-1:0] DIV_R = DIVISOR[R_W-1:0];

   typedef struct packed {
      logic [Q_W-1:0] q;
      logic [R_W-1:0] r;
   } qr_t;

   typedef struct packed {
      logic           rem_err;
      logic           ovf;
      logic [X_W-1:0] x;
   } res_t;

   function automatic logic rem_illegal(input logic [R_W-1:0] r);
      return (r >= DIV_R);
   endfunction

endpackage

// File: rtl/pipe_stage.sv
// One valid/ready register slice: accepts when empty or when its own content
// leaves this cycle; holds data and valid while the downstream stalls.
module pipe_stage #(
   parameter int WIDTH = 8
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_data
);

   logic             r_valid;
   logic [WIDTH-1:0] r_data;
   logic             w_adv;

   assign w_adv   = !r_valid || i_ready;
   assign o_ready = w_adv;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // slice register: load on advance, keep data when the upstream has nothing new
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (w_adv) begin
         r_valid <= i_valid;
         if (i_valid) begin
            r_data <= i_data;
         end
      end
   end

endmodule

// File: rtl/mul_5_recon.sv
// Rebuilds X = 5*Q + R from a quotient/remainder pair through a two-slice
// valid/ready pipeline, flagging illegal remainders and 32-bit overflow.
module mul_5_recon
   import div_const_pkg::*;
(
   input  logic           i_clk,
   input  logic           i_rst,
   input  logic           i_in_valid,
   output logic           o_in_ready,
   input  logic [Q_W-1:0] i_q_in,
   input  logic [R_W-1:0] i_r_in,
   output logic           o_out_valid,
   input  logic           i_out_ready,
   output logic [X_W-1:0] o_x_out,
   output logic           o_rem_err,
   output logic           o_ovf
);

   logic           r_rdy_en;
   logic           w_s1_in_valid;
   logic           w_s1_adv;
   logic           w_s1_valid;
   logic           w_s2_adv;
   qr_t            w_s1_din;
   qr_t            w_s1_dout;
   logic [S_W-1:0] w_q_x4;
   logic [S_W-1:0] w_q_x1;
   logic [S_W-1:0] w_r_ext;
   logic [S_W-1:0] w_sum;
   res_t           w_s2_din;
   res_t           w_s2_dout;

   // input side stays closed until the first clock after reset release
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdy_en <= 1'b0;
      end else begin
         r_rdy_en <= 1'b1;
      end
   end

   assign w_s1_in_valid = i_in_valid && r_rdy_en;
   assign o_in_ready    = w_s1_adv && r_rdy_en;
   assign w_s1_din      = {i_q_in, i_r_in};

   pipe_stage #(
      .WIDTH ($bits(qr_t))
   ) u_s1 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (w_s1_in_valid),
      .o_ready (w_s1_adv),
      .i_data  (w_s1_din),
      .o_valid (w_s1_valid),
      .i_ready (w_s2_adv),
      .o_data  (w_s1_dout)
   );

   // 5*Q as (Q<<2)+Q, one bit wider than X so the carry becomes the overflow flag
   assign w_q_x4   = {{(S_W-Q_W-2){1'b0}}, w_s1_dout.q, 2'b00};
   assign w_q_x1   = {{(S_W-Q_W){1'b0}}, w_s1_dout.q};
   assign w_r_ext  = {{(S_W-R_W){1'b0}}, w_s1_dout.r};
   assign w_sum    = w_q_x4 + w_q_x1 + w_r_ext;
   assign w_s2_din = {rem_illegal(w_s1_dout.r), w_sum[X_W], w_sum[X_W-1:0]};

   pipe_stage #(
      .WIDTH ($bits(res_t))
   ) u_s2 (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_valid (w_s1_valid),
      .o_ready (w_s2_adv),
      .i_data  (w_s2_din),
      .o_valid (o_out_valid),
      .i_ready (i_out_ready),
      .o_data  (w_s2_dout)
   );

   assign o_x_out   = w_s2_dout.x;
   assign o_rem_err = w_s2_dout.rem_err;
   assign o_ovf     = w_s2_dout.ovf;

endmodule

// File: tb/tb_mul_5_recon.sv
// Bench for mul_5_recon: directed vector table, random streaming and backpressure
// against an arithmetic reference, and a reset with results in flight.
module tb_mul_5_recon;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [29:0] q_in = 30'd0;
   logic [2:0]  r_in = 3'd0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] x_out;
   logic        rem_err;
   logic        ovf;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mul_5_recon dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_in_valid  (in_valid),
      .o_in_ready  (in_ready),
      .i_q_in      (q_in),
      .i_r_in      (r_in),
      .o_out_valid (out_valid),
      .i_out_ready (out_ready),
      .o_x_out     (x_out),
      .o_rem_err   (rem_err),
      .o_ovf       (ovf)
   );

   typedef struct {
      logic [29:0] q;
      logic [2:0]  r;
      logic [31:0] x;
      logic        re;
      logic        ov;
   } vec_t;

   typedef struct packed {
      logic [29:0] q;
      logic [2:0]  r;
   } pair_t;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   // reference: plain integer arithmetic, returns {rem_err, ovf, x}
   function automatic logic [33:0] model(input logic [29:0] q, input logic [2:0] r);
      longint unsigned v;
      v = 64'd5 * 64'(q) + 64'(r);
      return {(r >= 3'd5), (v >= 64'h1_0000_0000), v[31:0]};
   endfunction

   task automatic apply_one(input logic [29:0] q, input logic [2:0] r,
                            output logic [33:0] res, output int lat);
      @(negedge clk);
      in_valid  = 1'b1;
      q_in      = q;
      r_in      = r;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      res = {rem_err, ovf, x_out};
   endtask

   task automatic run_traffic(input int n, input int pct_rdy, input bit always_valid,
                              input bit legal, output int cycles);
      pair_t       expq[$];
      pair_t       e;
      logic [33:0] m;
      logic [33:0] prev_out = 34'd0;
      bit          prev_stall = 1'b0;
      bit          pend = 1'b0;
      logic [29:0] pq = 30'd0;
      logic [2:0]  pr = 3'd0;
      int          sent = 0;
      int          got = 0;
      int          cyc = 0;
      while (got < n && cyc < n * 20 + 100) begin
         @(negedge clk);
         if (!pend && sent < n && (always_valid || $urandom_range(0, 99) < 70)) begin
            pend = 1'b1;
            pq   = 30'($urandom());
            pr   = legal ? 3'($urandom_range(0, 4)) : 3'($urandom_range(0, 7));
         end
         in_valid  = pend;
         q_in      = pq;
         r_in      = pr;
         out_ready = (pct_rdy >= 100) ? 1'b1 : ($urandom_range(0, 99) < pct_rdy);
         #1;
         check("in_ready", 64'(in_ready), 64'(!(expq.size() == 2 && !out_ready)));
         if (expq.size() == 0) check("idle_out_valid", 64'(out_valid), 64'd0);
         if (prev_stall) begin
            check("stall_valid", 64'(out_valid), 64'd1);
            check("stall_data", 64'({rem_err, ovf, x_out}), 64'(prev_out));
         end
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check("dup_output", 64'd1, 64'd0);
            end else begin
               e = expq.pop_front();
               m = model(e.q, e.r);
               check("stream_result", 64'({rem_err, ovf, x_out}), 64'(m));
               if (e.r < 3'd5 && !m[32]) begin
                  check("div_q", 64'(x_out / 32'd5), 64'(e.q));
                  check("div_r", 64'(x_out % 32'd5), 64'(e.r));
               end
            end
            got++;
         end
         prev_stall = out_valid && !out_ready;
         prev_out   = {rem_err, ovf, x_out};
         if (in_valid && in_ready) begin
            expq.push_back('{q: pq, r: pr});
            sent++;
            pend = 1'b0;
         end
         cyc++;
      end
      check("result_count", 64'(got), 64'(n));
      check("leftover", 64'(expq.size()), 64'd0);
      in_valid = 1'b0;
      cycles   = cyc;
   endtask

   initial begin
      vec_t        tbl[8];
      logic [33:0] res;
      int          lat;
      int          cycles;
      bit          seen;

      tbl[0] = '{30'h0000_0007, 3'd3, 32'h0000_0026, 1'b0, 1'b0};
      tbl[1] = '{30'h0000_0000, 3'd5, 32'h0000_0005, 1'b1, 1'b0};
      tbl[2] = '{30'h3333_3333, 3'd1, 32'h0000_0000, 1'b0, 1'b1};
      tbl[3] = '{30'h3333_3333, 3'd0, 32'hFFFF_FFFF, 1'b0, 1'b0};
      tbl[4] = '{30'h0000_0000, 3'd0, 32'h0000_0000, 1'b0, 1'b0};
      tbl[5] = '{30'h3FFF_FFFF, 3'd7, 32'h4000_0002, 1'b1, 1'b1};
      tbl[6] = '{30'h3FFF_FFFF, 3'd4, 32'h3FFF_FFFF, 1'b0, 1'b1};
      tbl[7] = '{30'h1234_5678, 3'd2, 32'h5B05_B05A, 1'b0, 1'b0};

      // reset state
      repeat (3) @(negedge clk);
      #1;
      check("rst_in_ready", 64'(in_ready), 64'd0);
      check("rst_out", 64'({out_valid, rem_err, ovf, x_out}), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      #1;
      check("post_rst_in_ready", 64'(in_ready), 64'd1);
      check("post_rst_out_valid", 64'(out_valid), 64'd0);

      // directed vectors
      for (int i = 0; i < 8; i++) begin
         apply_one(tbl[i].q, tbl[i].r, res, lat);
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd2);
         check($sformatf("vec%0d_x", i), 64'(res[31:0]), 64'(tbl[i].x));
         check($sformatf("vec%0d_ovf", i), 64'(res[32]), 64'(tbl[i].ov));
         check($sformatf("vec%0d_rem_err", i), 64'(res[33]), 64'(tbl[i].re));
      end
      @(negedge clk);

      // streaming: full throughput, legal pairs
      run_traffic(1000, 100, 1'b1, 1'b1, cycles);
      check("stream_cycles", 64'(cycles), 64'd1002);

      // backpressure: 30% ready, sparse input, any remainder
      run_traffic(400, 30, 1'b0, 1'b0, cycles);

      // reset with two results in flight
      @(negedge clk);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      q_in      = 30'd1;
      r_in      = 3'd1;
      @(negedge clk);
      q_in = 30'd2;
      r_in = 3'd2;
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      check("inflight_valid", 64'(out_valid), 64'd1);
      check("inflight_x", 64'(x_out), 64'd6);
      check("inflight_in_ready", 64'(in_ready), 64'd0);
      rst      = 1'b1;
      in_valid = 1'bx;
      #1;
      check("mid_rst_out", 64'({out_valid, rem_err, ovf, x_out}), 64'd0);
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      seen      = 1'b0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
      check("post_rst_no_output", 64'(seen), 64'd0);
      check("post_rst_ready_again", 64'(in_ready), 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
